// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename/dispatch controller and its ROB allocator.
package rename_pkg;
  localparam int NUM_ROWS   = 32;
  localparam int ROBID_BITS = 7;
  localparam int REGID_BITS = 5;
  localparam int ROB_DEPTH  = 1 << ROBID_BITS;

  localparam logic [REGID_BITS-1:0] LAST_ROW      = REGID_BITS'(NUM_ROWS - 1);
  localparam logic [ROBID_BITS:0]   ROB_DEPTH_CNT = (ROBID_BITS + 1)'(ROB_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rename_state_t;

  typedef struct packed {
    logic [ROBID_BITS-1:0] robid;
    logic [ROBID_BITS-1:0] robid1;
    logic [ROBID_BITS-1:0] robid2;
    logic                  v1;
    logic                  v2;
  } ren_out_t;
endpackage

// File: rtl/rob_alloc_cnt.sv
// ROB allocation tracking: tail pointer, live-entry count and full flag.
// clr wins over inc/dec; a dec with an empty ROB is ignored.
module rob_alloc_cnt import rename_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clr,
  output logic [ROBID_BITS-1:0] tail,
  output logic [ROBID_BITS:0]   count,
  output logic                  full
);
  logic [ROBID_BITS-1:0] tail_q, tail_d;
  logic [ROBID_BITS:0]   count_q, count_d;
  logic                  do_inc, do_dec;

  always_comb begin
    tail_d  = tail_q;
    count_d = count_q;
    do_inc  = inc && (count_q != ROB_DEPTH_CNT);
    do_dec  = dec && (count_q != '0);
    if (clr) begin
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Tail width equals log2(ROB_DEPTH), so the increment wraps 127 -> 0.
      if (do_inc) tail_d = tail_q + 1'b1;
      if (do_inc && !do_dec)      count_d = count_q + 1'b1;
      else if (!do_inc && do_dec) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == ROB_DEPTH_CNT);
endmodule

// File: rtl/rename_ctrl.sv
// Rename/dispatch controller: ROB-ID allocation, delayed RAT rename write,
// single-entry renamed-output register and RAT flush walk.
// Optional RENAME_PERF_EN adds saturating stall/rename performance counters.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high; valid never depends combinationally on ready of the same interface.
module rename_ctrl import rename_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REGID_BITS-1:0] dec_rs1,
  input  logic [REGID_BITS-1:0] dec_rs2,
  input  logic [REGID_BITS-1:0] dec_rd,
  input  logic                  dec_has_rd,
  output logic                  ren_valid,
  input  logic                  ren_ready,
  output logic [ROBID_BITS-1:0] ren_robid,
  output logic [ROBID_BITS-1:0] ren_robid1,
  output logic [ROBID_BITS-1:0] ren_robid2,
  output logic                  ren_v1,
  output logic                  ren_v2,
  output logic [REGID_BITS-1:0] rat_r1addr,
  output logic [REGID_BITS-1:0] rat_r2addr,
  input  logic [ROBID_BITS-1:0] rat_robid1,
  input  logic [ROBID_BITS-1:0] rat_robid2,
  input  logic                  rat_v1,
  input  logic                  rat_v2,
  output logic [REGID_BITS-1:0] rat_waddr,
  output logic                  rat_write_robid,
  output logic [ROBID_BITS-1:0] rat_currid,
  output logic                  rat_clr_valid,
  output logic [REGID_BITS-1:0] rat_clr_addr,
  input  logic                  commit_valid,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  rob_full,
  output logic [ROBID_BITS:0]   rob_count,
  output rename_state_t         dbg_state
`ifdef RENAME_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_renamed
`endif
);
  rename_state_t         state_q, state_d;
  logic [REGID_BITS-1:0] clr_addr_q, clr_addr_d;
  ren_out_t              ren_q, ren_d;
  logic                  ren_valid_q, ren_valid_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [REGID_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [ROBID_BITS-1:0] wr_id_q, wr_id_d;
  logic [ROBID_BITS-1:0] tail;
  logic                  run, accept, commit;

  assign run       = (state_q == RUN);
  // Held low while reset is asserted so decode never sees a stale ready.
  assign dec_ready = rst && run && !rob_full && (!ren_valid_q || ren_ready);
  assign accept    = dec_valid && dec_ready;
  assign commit    = commit_valid && run;

  rob_alloc_cnt u_alloc (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .dec   (commit),
    .clr   (flush_req),
    .tail  (tail),
    .count (rob_count),
    .full  (rob_full)
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    ren_d       = ren_q;
    ren_valid_d = ren_valid_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_id_d     = wr_id_q;

    case (state_q)
      RUN: begin
        clr_addr_d = '0;
      end
      FLUSH: begin
        if (clr_addr_q == LAST_ROW) begin
          state_d    = RUN;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (accept) begin
      ren_d.robid  = tail;
      ren_d.robid1 = rat_robid1;
      ren_d.robid2 = rat_robid2;
      ren_d.v1     = rat_v1;
      ren_d.v2     = rat_v2;
      ren_valid_d  = 1'b1;
      // The RAT row is rewritten one cycle later, so rs == rd in the same
      // instruction still reads the previous producer.
      wr_valid_d   = dec_has_rd;
      wr_addr_d    = dec_rd;
      wr_id_d      = tail;
    end else if (ren_ready) begin
      ren_valid_d = 1'b0;
    end

    if (flush_req) begin
      state_d     = FLUSH;
      clr_addr_d  = '0;
      ren_valid_d = 1'b0;
      wr_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      clr_addr_q  <= '0;
      ren_q       <= '0;
      ren_valid_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      ren_q       <= ren_d;
      ren_valid_q <= ren_valid_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_id_q     <= wr_id_d;
    end
  end

  assign rat_r1addr      = dec_rs1;
  assign rat_r2addr      = dec_rs2;
  assign rat_write_robid = wr_valid_q;
  assign rat_waddr       = wr_addr_q;
  assign rat_currid      = wr_id_q;
  assign rat_clr_valid   = (state_q == FLUSH);
  assign rat_clr_addr    = clr_addr_q;
  assign flush_busy      = (state_q == FLUSH);
  assign dbg_state       = state_q;
  assign ren_valid       = ren_valid_q;
  assign ren_robid       = ren_q.robid;
  assign ren_robid1      = ren_q.robid1;
  assign ren_robid2      = ren_q.robid2;
  assign ren_v1          = ren_q.v1;
  assign ren_v2          = ren_q.v2;

`ifdef RENAME_PERF_EN
  logic [31:0] stall_q, stall_d, renamed_q, renamed_d;

  always_comb begin
    stall_d   = stall_q;
    renamed_d = renamed_q;
    if (dec_valid && !dec_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (accept && (renamed_q != '1))                renamed_d = renamed_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q   <= '0;
      renamed_q <= '0;
    end else begin
      stall_q   <= stall_d;
      renamed_q <= renamed_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_renamed      = renamed_q;
`endif
endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: directed vector table, corner-case
// sequences and random traffic against a program-order rename model.
module tb_rename_ctrl;
  import rename_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  dec_valid = 1'b0;
  logic                  dec_ready;
  logic [REGID_BITS-1:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic                  dec_has_rd = 1'b0;
  logic                  ren_valid;
  logic                  ren_ready = 1'b0;
  logic [ROBID_BITS-1:0] ren_robid, ren_robid1, ren_robid2;
  logic                  ren_v1, ren_v2;
  logic [REGID_BITS-1:0] rat_r1addr, rat_r2addr;
  logic [ROBID_BITS-1:0] rat_robid1, rat_robid2;
  logic                  rat_v1, rat_v2;
  logic [REGID_BITS-1:0] rat_waddr;
  logic                  rat_write_robid;
  logic [ROBID_BITS-1:0] rat_currid;
  logic                  rat_clr_valid;
  logic [REGID_BITS-1:0] rat_clr_addr;
  logic                  commit_valid = 1'b0;
  logic                  flush_req = 1'b0;
  logic                  flush_busy, rob_full;
  logic [ROBID_BITS:0]   rob_count;
  rename_state_t         dbg_state;
`ifdef RENAME_PERF_EN
  logic [31:0]           perf_stall_cycles, perf_renamed;
`endif

  rename_ctrl dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_has_rd(dec_has_rd),
    .ren_valid(ren_valid), .ren_ready(ren_ready), .ren_robid(ren_robid),
    .ren_robid1(ren_robid1), .ren_robid2(ren_robid2), .ren_v1(ren_v1), .ren_v2(ren_v2),
    .rat_r1addr(rat_r1addr), .rat_r2addr(rat_r2addr), .rat_robid1(rat_robid1),
    .rat_robid2(rat_robid2), .rat_v1(rat_v1), .rat_v2(rat_v2), .rat_waddr(rat_waddr),
    .rat_write_robid(rat_write_robid), .rat_currid(rat_currid),
    .rat_clr_valid(rat_clr_valid), .rat_clr_addr(rat_clr_addr),
    .commit_valid(commit_valid), .flush_req(flush_req), .flush_busy(flush_busy),
    .rob_full(rob_full), .rob_count(rob_count), .dbg_state(dbg_state)
`ifdef RENAME_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_renamed(perf_renamed)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAT stub: writes land mid-cycle ----------------
  logic [ROBID_BITS-1:0] stub_id [NUM_ROWS];
  logic                  stub_v  [NUM_ROWS];

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        stub_id[i] = '0;
        stub_v[i]  = 1'b1;
      end
    end else begin
      if (rat_write_robid) begin
        stub_id[rat_waddr] = rat_currid;
        stub_v[rat_waddr]  = 1'b0;
      end
      if (rat_clr_valid) begin
        stub_id[rat_clr_addr] = '0;
        stub_v[rat_clr_addr]  = 1'b1;
      end
    end
  end

  assign rat_robid1 = stub_id[rat_r1addr];
  assign rat_robid2 = stub_id[rat_r2addr];
  assign rat_v1     = stub_v[rat_r1addr];
  assign rat_v2     = stub_v[rat_r2addr];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (program-order rename) ----------------
  int m_tail, m_count, m_clr;   // m_clr: current flush row, -1 when running
  bit m_rv, m_wr;
  int m_robid, m_id1, m_id2;
  bit m_v1, m_v2;
  int m_wr_addr, m_wr_id;
  int m_map_id [NUM_ROWS];
  bit m_map_v  [NUM_ROWS];
  int m_stall, m_renamed;

  function automatic void model_map_init();
    for (int i = 0; i < NUM_ROWS; i++) begin
      m_map_id[i] = 0;
      m_map_v[i]  = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_tail = 0; m_count = 0; m_clr = -1;
    m_rv = 0; m_wr = 0;
    m_robid = 0; m_id1 = 0; m_id2 = 0; m_v1 = 0; m_v2 = 0;
    m_wr_addr = 0; m_wr_id = 0;
    m_stall = 0; m_renamed = 0;
    model_map_init();
  endfunction

  // One clock: drive, check ready before the edge, advance model, check after.
  task automatic step(input bit dv, input int rs1, input int rs2, input int rd,
                      input bit hrd, input bit rr, input bit cv, input bit fr);
    bit ready, acc, com;
    logic [4:0] a1, a2, ad;
    a1 = rs1[4:0]; a2 = rs2[4:0]; ad = rd[4:0];
    dec_valid = dv; dec_rs1 = a1; dec_rs2 = a2; dec_rd = ad; dec_has_rd = hrd;
    ren_ready = rr; commit_valid = cv; flush_req = fr;
    @(negedge clk);
    ready = (m_clr < 0) && (m_count < ROB_DEPTH) && (!m_rv || rr);
    check("dec_ready", dec_ready, ready);
    check("rat_r1addr", rat_r1addr, a1);
    check("rat_r2addr", rat_r2addr, a2);
    acc = dv && ready;
    com = cv && (m_clr < 0) && (m_count > 0);
    if (dv && !ready) m_stall++;
    if (acc) m_renamed++;
    if (fr) begin
      m_rv = 0; m_wr = 0; m_tail = 0; m_count = 0; m_clr = 0;
      model_map_init();
    end else begin
      if (m_clr >= 0) m_clr = (m_clr == NUM_ROWS - 1) ? -1 : m_clr + 1;
      m_wr = 0;
      if (acc) begin
        m_robid = m_tail;
        m_id1 = m_map_id[a1]; m_v1 = m_map_v[a1];
        m_id2 = m_map_id[a2]; m_v2 = m_map_v[a2];
        m_rv = 1;
        if (hrd) begin
          m_wr = 1; m_wr_addr = ad; m_wr_id = m_tail;
          m_map_id[ad] = m_tail; m_map_v[ad] = 1'b0;
        end
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end else if (rr) begin
        m_rv = 0;
      end
      m_count = m_count + int'(acc) - int'(com);
    end
    @(posedge clk); #1;
    check("ren_valid", ren_valid, m_rv);
    if (m_rv) begin
      check("ren_robid", ren_robid, m_robid);
      check("ren_robid1", ren_robid1, m_id1);
      check("ren_v1", ren_v1, m_v1);
      check("ren_robid2", ren_robid2, m_id2);
      check("ren_v2", ren_v2, m_v2);
    end
    check("rat_write_robid", rat_write_robid, m_wr);
    if (m_wr) begin
      check("rat_waddr", rat_waddr, m_wr_addr);
      check("rat_currid", rat_currid, m_wr_id);
    end
    check("rob_count", rob_count, m_count);
    check("rob_full", rob_full, m_count == ROB_DEPTH);
    check("flush_busy", flush_busy, m_clr >= 0);
    check("rat_clr_valid", rat_clr_valid, m_clr >= 0);
    check("dbg_state", dbg_state, (m_clr >= 0) ? FLUSH : RUN);
    if (m_clr >= 0) check("rat_clr_addr", rat_clr_addr, m_clr);
  endtask

  task automatic idle(input bit rr);
    step(0, 0, 0, 0, 0, rr, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ren_valid"}, ren_valid, 0);
    check({tag, "_ren_robid"}, ren_robid, 0);
    check({tag, "_rat_write"}, rat_write_robid, 0);
    check({tag, "_clr_valid"}, rat_clr_valid, 0);
    check({tag, "_rob_count"}, rob_count, 0);
    check({tag, "_rob_full"}, rob_full, 0);
    check({tag, "_flush_busy"}, flush_busy, 0);
    check({tag, "_dec_ready"}, dec_ready, 0);
  endtask

  task automatic do_reset();
    dec_valid = 0; ren_ready = 0; commit_valid = 0; flush_req = 0; dec_has_rd = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("post_reset_dec_ready", dec_ready, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int dv, rs1, rs2, rd, hrd, rr, cv;
    int rv, robid, id1, v1, id2, v2;
    int wr, waddr, currid, cnt;
  } tv_t;

  tv_t tv [9];

  initial begin
    int clr_seen;
    bit dv, hrd, rr, cv, fr;

    model_reset();
    do_reset();

    //         dv rs1 rs2 rd hrd rr cv | rv robid id1 v1 id2 v2 | wr waddr currid | cnt
    tv[0] = '{1, 3, 4, 5, 1, 1, 0,   1, 0, 0, 1, 0, 1,   1, 5, 0,   1};
    tv[1] = '{1, 5, 3, 6, 1, 1, 0,   1, 1, 0, 0, 0, 1,   1, 6, 1,   2};
    tv[2] = '{1, 6, 5, 7, 0, 1, 0,   1, 2, 1, 0, 0, 0,   0, 0, 0,   3};
    tv[3] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,   3};
    tv[4] = '{1, 1, 2, 1, 1, 0, 0,   1, 3, 0, 1, 0, 1,   1, 1, 3,   4};
    tv[5] = '{1, 1, 0, 2, 0, 0, 0,   1, 3, 0, 1, 0, 1,   0, 0, 0,   4};
    tv[6] = '{1, 1, 0, 2, 0, 1, 0,   1, 4, 3, 0, 0, 1,   0, 0, 0,   5};
    tv[7] = '{0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0,   0, 0, 0,   4};
    tv[8] = '{1, 7, 6, 0, 1, 1, 1,   1, 5, 0, 1, 1, 0,   1, 0, 5,   4};

    for (int i = 0; i < 9; i++) begin
      step(tv[i].dv[0], tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].hrd[0],
           tv[i].rr[0], tv[i].cv[0], 1'b0);
      check("tv_ren_valid", ren_valid, tv[i].rv);
      if (tv[i].rv != 0) begin
        check("tv_ren_robid", ren_robid, tv[i].robid);
        check("tv_ren_robid1", ren_robid1, tv[i].id1);
        check("tv_ren_v1", ren_v1, tv[i].v1);
        check("tv_ren_robid2", ren_robid2, tv[i].id2);
        check("tv_ren_v2", ren_v2, tv[i].v2);
      end
      check("tv_rat_write", rat_write_robid, tv[i].wr);
      if (tv[i].wr != 0) begin
        check("tv_rat_waddr", rat_waddr, tv[i].waddr);
        check("tv_rat_currid", rat_currid, tv[i].currid);
      end
      check("tv_rob_count", rob_count, tv[i].cnt);
    end

    // ---- full boundary and tail wrap ----
    do_reset();
    for (int i = 0; i < 127; i++)
      step(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           1'($urandom_range(0, 1)), 1, 0, 0);
    check("cnt127_count", rob_count, 127);
    check("cnt127_full", rob_full, 0);
    step(1, 1, 2, 3, 1, 1, 0, 0);
    check("full_count", rob_count, 128);
    check("full_flag", rob_full, 1);
    check("full_dec_ready", dec_ready, 0);
    step(1, 4, 5, 6, 1, 1, 1, 0);
    check("unfull_count", rob_count, 127);
    check("unfull_dec_ready", dec_ready, 1);
    step(1, 7, 8, 9, 1, 1, 1, 0);
    check("acc_commit_count", rob_count, 127);
    check("wrap_robid", ren_robid, 0);
    step(1, 9, 10, 11, 1, 1, 0, 0);
    check("wrap_next_robid", ren_robid, 1);
    check("refull_flag", rob_full, 1);

    // ---- flush with ren_valid high ----
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("flush_ren_valid", ren_valid, 0);
    check("flush_count", rob_count, 0);
    clr_seen = 0;
    for (int k = 0; k < 40 && rat_clr_valid; k++) begin
      check("flush_walk_addr", rat_clr_addr, clr_seen);
      clr_seen++;
      idle(1);
    end
    check("flush_clear_cycles", clr_seen, NUM_ROWS);
    check("flush_done_ready", dec_ready, 1);
    step(1, 5, 6, 7, 1, 1, 0, 0);
    check("post_flush_robid", ren_robid, 0);

    // ---- flush restarted mid-walk ----
    step(0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) idle(1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    check("restart_addr", rat_clr_addr, 0);
    for (int k = 0; k < 40 && m_clr >= 0; k++) idle(1);

    // ---- async reset at clear row 10 ----
    step(1, 1, 2, 3, 1, 0, 0, 1);
    for (int k = 0; k < 20 && m_clr != 10; k++) idle(0);
    check("pre_rst_clr_addr", rat_clr_addr, 10);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midflush");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) idle(1);

    // ---- random traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      dv  = ($urandom_range(0, 99) < 70);
      hrd = ($urandom_range(0, 99) < 75);
      rr  = ($urandom_range(0, 99) < 70);
      cv  = ($urandom_range(0, 99) < 45);
      fr  = ($urandom_range(0, 299) == 0);
      step(dv, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           hrd, rr, cv, fr);
    end

`ifdef RENAME_PERF_EN
    check("perf_renamed", perf_renamed, m_renamed);
    check("perf_stall_cycles", perf_stall_cycles, m_stall);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
